instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the RV32 integer core.
- Owns the PC and the instruction register.
- Fetches from instruction memory over a req/ack handshake.
- Presents the latched instruction to the decode/control logic.
- Gates register-file writes to one cycle per retired instruction.
- Halts on EBREAK, on an unsupported opcode, or on a fetch timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 64, max cycles in FETCH without imem_ack before fault; must be >= 2

Ports:
clk  in  1  core clock
resetn  in  1  reset, synchronous, active-low
run  in  1  enable instruction sequencing
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register, to control unit
instr_valid  out  1  instr is being executed (EXEC state)
reg_write_in  in  1  write request from control unit decode
rf_we  out  1  gated register-file write enable
pc  out  32  current program counter
halted  out  1  core in HALT state
fault  out  1  halt was caused by an error
retired_count  out  32  instructions retired

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, instr=0, retired_count=0, fault=0, watchdog=0.
  - All outputs low except pc.
  - Reset overrides any in-flight fetch; imem_req is low from the next cycle.
- States: IDLE, FETCH, EXEC, WB, HALT. All outputs are registered or decoded from state only.
- IDLE:
  - Outputs idle.
  - run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - Watchdog clears on entry and counts each FETCH cycle.
  - imem_ack=1: instr<=imem_rdata, -> EXEC.
  - No ack and watchdog==TIMEOUT_CYCLES-1: -> HALT with fault=1.
  - Ack and timeout in the same cycle: ack wins.
  - run dropping during FETCH does not abort the fetch.
- EXEC (one cycle):
  - instr_valid=1.
  - opcode 7'b0110011 or 7'b0010011 -> WB.
  - instr==32'h0010_0073 (EBREAK) -> HALT, fault=0.
  - Any other encoding -> HALT, fault=1; pc stays at the offending instruction.
- WB (one cycle):
  - rf_we=reg_write_in.
  - pc<=pc+4, wrapping modulo 2^32.
  - retired_count++, wrapping.
  - run=1 -> FETCH; run=0 -> IDLE.
- HALT:
  - Sticky until reset; halted=1; fault holds its value.
  - run is ignored; imem_ack is ignored.
- imem_ack outside FETCH is ignored.
- rf_we is never high outside WB.
- Throughput: 3 cycles per instruction (FETCH, EXEC, WB) when ack arrives in the first FETCH cycle; +1 cycle per wait cycle.
- Latency from IDLE with run=1 to first imem_req: 1 cycle.

Decomposition:
- Shared package core_pkg:
  - seq_state_t enum (IDLE, FETCH, EXEC, WB, HALT).
  - OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011.
  - INSTR_EBREAK=32'h0010_0073.
  - PC_STEP=4.
- One sub-module, fetch_watchdog:
  - Inputs: clear, count-enable.
  - Parameter: TIMEOUT_CYCLES.
  - Output: expired.
- FSM, PC, IR and retire counter live in instr_sequencer.

Test Plan:
- Basic retire:
  - Stimulus: reset, run=1; memory acks in the first FETCH cycle with 0x00208033 (add), then 0x00100073; reg_write_in=1.
  - Required: imem_req in cycle 1; rf_we pulses once in cycle 3; pc 0->4; retired_count=1; then HALT with halted=1, fault=0.
- Wait states:
  - Stimulus: ack delayed 5 cycles.
  - Required: imem_req and imem_addr stable for 6 cycles; instr latched only on the ack cycle.
  - Stimulus: ack asserted while in IDLE.
  - Required: ack ignored; instr unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, never ack.
  - Required: HALT after 4 FETCH cycles; fault=1; pc unchanged.
  - Stimulus: ack on the 4th FETCH cycle.
  - Required: EXEC, no fault.
- Illegal opcode:
  - Stimulus: 0x00000003 (load) fetched at pc=0x8.
  - Required: HALT, fault=1, pc=0x8, rf_we never asserted, retired_count unchanged.
- Run control and reset:
  - Stimulus: run=0 asserted during FETCH.
  - Required: fetch completes, instruction retires, then IDLE.
  - Stimulus: resetn=0 in EXEC.
  - Required: next cycle state=IDLE, pc=RESET_PC, instr_valid=0, retired_count=0.
- Wrap:
  - Stimulus: RESET_PC=32'hFFFF_FFFC, one ADDI retired.
  - Required: pc=32'h0000_0000; next imem_addr=0.

Source files
------------

// File: rtl/core_pkg.sv
`timescale 1ns/1ps
// core_pkg
// Shared definitions for the RV32 fetch/execute sequencer:
//   seq_state_t   - sequencer FSM states
//   OPC_RTYPE/ITYPE, INSTR_EBREAK - encodings the sequencer recognises
//   PC_STEP       - PC increment per retired instruction
//   is_alu_op()   - true when the opcode belongs to a register/immediate ALU op
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  localparam logic [6:0]  OPC_RTYPE    = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE    = 7'b0010011;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] PC_STEP      = 32'd4;

  function automatic logic is_alu_op(input logic [31:0] word);
    return (word[6:0] == OPC_RTYPE) || (word[6:0] == OPC_ITYPE);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
`timescale 1ns/1ps
// fetch_watchdog
// Counts cycles spent waiting for an instruction-memory acknowledge.
// Ports:
//   clk, resetn  - core clock, synchronous active-low reset
//   clear        - restart the count (held while not fetching)
//   count_en     - one more fetch cycle has elapsed
//   expired      - current cycle is the last allowed fetch cycle
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Cycle counter; saturates at the last allowed cycle so it can never wrap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en && (count_r != LAST)) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer
// Multi-cycle FETCH -> EXEC -> WB sequencer for the RV32 integer core. Owns
// the PC, the instruction register and the retire counter, and halts on
// EBREAK, an unsupported opcode or a fetch timeout.
// Ports:
//   clk, resetn          - core clock, synchronous active-low reset
//   run                  - allow sequencing to start / continue
//   imem_req, imem_addr  - fetch request and address (address is the PC)
//   imem_ack, imem_rdata - fetch response; data sampled on the ack cycle
//   instr, instr_valid   - instruction register and its EXEC qualifier
//   reg_write_in, rf_we  - decode write request and its WB-gated version
//   pc                   - program counter
//   halted, fault        - HALT state and whether it was caused by an error
//   retired_count        - number of retired instructions (wraps)
module instr_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        reg_write_in,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  seq_state_t  state_r;
  seq_state_t  next_state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] retired_r;
  logic        fault_r;
  logic        wb_s;
  logic        wd_expired_s;

  // The watchdog restarts whenever we are outside FETCH, so every fetch
  // begins with a fresh count.
  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (state_r != FETCH),
    .count_en (state_r == FETCH),
    .expired  (wd_expired_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; an acknowledge beats a simultaneous timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) next_state_s = FETCH;
        else     next_state_s = IDLE;
      end
      FETCH: begin
        if (imem_ack)          next_state_s = EXEC;
        else if (wd_expired_s) next_state_s = HALT;
        else                   next_state_s = FETCH;
      end
      EXEC: begin
        if (is_alu_op(instr_r)) next_state_s = WB;
        else                    next_state_s = HALT;
      end
      WB: begin
        if (run) next_state_s = FETCH;
        else     next_state_s = IDLE;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = HALT;
    endcase
  end

  // FSM output decode: every qualifier depends on the state alone
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    wb_s        = 1'b0;
    case (state_r)
      IDLE:    imem_req    = 1'b0;
      FETCH:   imem_req    = 1'b1;
      EXEC:    instr_valid = 1'b1;
      WB:      wb_s        = 1'b1;
      HALT:    halted      = 1'b1;
      default: halted      = 1'b1;
    endcase
  end

  // Instruction register: loads only on an acknowledged fetch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_r <= 32'h0000_0000;
    end else if ((state_r == FETCH) && imem_ack) begin
      instr_r <= imem_rdata;
    end else begin
      instr_r <= instr_r;
    end
  end

  // PC and retire counter advance once per instruction, in WB; both wrap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r      <= RESET_PC;
      retired_r <= 32'h0000_0000;
    end else if (state_r == WB) begin
      pc_r      <= pc_r + PC_STEP;
      retired_r <= retired_r + 32'd1;
    end else begin
      pc_r      <= pc_r;
      retired_r <= retired_r;
    end
  end

  // Fault flag: set on a timed-out fetch or an unsupported, non-EBREAK
  // instruction; held through HALT until reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (!imem_ack && wd_expired_s) fault_r <= 1'b1;
          else                           fault_r <= fault_r;
        end
        EXEC: begin
          if (!is_alu_op(instr_r) && (instr_r != INSTR_EBREAK)) fault_r <= 1'b1;
          else                                                    fault_r <= fault_r;
        end
        default: fault_r <= fault_r;
      endcase
    end
  end

  assign imem_addr     = pc_r;
  assign pc            = pc_r;
  assign instr         = instr_r;
  assign fault         = fault_r;
  assign retired_count = retired_r;
  assign rf_we         = wb_s & reg_write_in;

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for instr_sequencer. The stimulus side acts as
// instruction memory, predicts each instruction's outcome from the ISA rules
// and queues it; a monitor pops and compares on EXEC and on HALT entry.
module tb_instr_sequencer;

  localparam logic [31:0] RST_PC  = 32'hFFFF_FFFC;
  localparam int          TMO     = 8;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_I    = 7'b0010011;

  logic        clk = 1'b0;
  logic        resetn, run, imem_ack, reg_write_in;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, rf_we, halted, fault;
  logic [31:0] imem_addr, instr, pc, retired_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_halt;
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] ret;
    bit          fault;
    bit          retires;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_ret, m_ir;

  instr_sequencer #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .reg_write_in  (reg_write_in),
    .rf_we         (rf_we),
    .pc            (pc),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [31:0] w);
    return (w[6:0] == OP_R) || (w[6:0] == OP_I);
  endfunction

  function automatic logic [31:0] mk_alu(input logic [6:0] opc);
    logic [31:0] w;
    w      = $urandom();
    w[6:0] = opc;
    return w;
  endfunction

  function automatic logic [31:0] mk_illegal();
    logic [31:0] w;
    w = $urandom();
    while (is_legal(w) || (w == EBREAK)) w = $urandom();
    return w;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; run = 1'b1; imem_ack = 1'b1; reg_write_in = 1'b1;
    imem_rdata = $urandom();
    step();
    step();
    resetn = 1'b1; run = 1'b0; imem_ack = 1'b0;
    m_pc = RST_PC; m_ret = 32'd0; m_ir = 32'd0;
    check("reset_pc", pc, RST_PC);
    check("reset_addr", imem_addr, RST_PC);
    check("reset_instr", instr, 32'd0);
    check("reset_retired", retired_count, 32'd0);
    check_bit("reset_req", imem_req, 1'b0);
    check_bit("reset_valid", instr_valid, 1'b0);
    check_bit("reset_rf_we", rf_we, 1'b0);
    check_bit("reset_halted", halted, 1'b0);
    check_bit("reset_fault", fault, 1'b0);
  endtask

  // Serve one fetch: wait for the request, stall 'delay' cycles, then ack.
  // delay >= TMO means the fetch is never acknowledged.
  task automatic do_fetch(input logic [31:0] word, input int delay, input bit drop_run);
    exp_t e;
    int   k;
    k = 0;
    while (!imem_req && (k < 12)) begin
      run = 1'b1; imem_ack = 1'b0; reg_write_in = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check_bit("fetch_req_seen", imem_req, 1'b1);
    if (drop_run) run = 1'b0;
    if (delay >= TMO) begin
      e.is_halt = 1'b1; e.pc = m_pc; e.word = m_ir; e.ret = m_ret;
      e.fault = 1'b1; e.retires = 1'b0;
      sb.push_back(e);
      for (int i = 0; i < TMO; i++) begin
        check_bit("tmo_req_held", imem_req, 1'b1);
        check("tmo_addr_held", imem_addr, m_pc);
        imem_ack = 1'b0; imem_rdata = $urandom();
        step();
      end
    end else begin
      for (int i = 0; i < delay; i++) begin
        check_bit("wait_req_held", imem_req, 1'b1);
        check("wait_addr_held", imem_addr, m_pc);
        check("wait_instr_unlatched", instr, m_ir);
        imem_ack = 1'b0; imem_rdata = $urandom();
        reg_write_in = 1'($urandom_range(0, 1));
        step();
      end
      check_bit("ack_cycle_req", imem_req, 1'b1);
      check("ack_cycle_addr", imem_addr, m_pc);
      e.is_halt = 1'b0; e.pc = m_pc; e.word = word; e.ret = m_ret;
      e.fault = 1'b0; e.retires = is_legal(word);
      sb.push_back(e);
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0; imem_rdata = $urandom();
      m_ir = word;
      if (is_legal(word)) begin
        m_pc  = m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
      end else begin
        e.is_halt = 1'b1; e.fault = (word != EBREAK); e.retires = 1'b0;
        sb.push_back(e);
      end
    end
  endtask

  // Sit in HALT with noisy run/ack and confirm nothing moves
  task automatic hold_halt(input bit exp_fault);
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom_range(0, 1)); imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom(); reg_write_in = 1'($urandom_range(0, 1));
      step();
    end
    imem_ack = 1'b0;
    check_bit("halt_sticky", halted, 1'b1);
    check_bit("halt_fault", fault, exp_fault);
    check("halt_pc", pc, m_pc);
    check("halt_instr", instr, m_ir);
    check("halt_retired", retired_count, m_ret);
    check_bit("halt_no_req", imem_req, 1'b0);
  endtask

  // Monitor: compares DUT activity against the scoreboard queue
  initial begin
    exp_t e;
    bit   wb_pending;
    bit   halted_q;
    wb_pending = 1'b0;
    halted_q   = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_pending) begin
        check_bit("wb_rf_we", rf_we, reg_write_in);
        wb_pending = 1'b0;
      end else if (rf_we) begin
        check_bit("rf_we_outside_wb", rf_we, 1'b0);
      end
      if (instr_valid) begin
        if (sb.size() == 0) begin
          check_bit("exec_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check_bit("exec_kind_is_halt", 1'(e.is_halt), 1'b0);
          check("exec_instr", instr, e.word);
          check("exec_pc", pc, e.pc);
          check("exec_retired", retired_count, e.ret);
          wb_pending = e.retires && resetn;
        end
      end
      if (halted && !halted_q) begin
        if (sb.size() == 0) begin
          check_bit("halt_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check_bit("halt_kind_is_halt", 1'(e.is_halt), 1'b1);
          check_bit("halt_entry_fault", fault, e.fault);
          check("halt_entry_pc", pc, e.pc);
          check("halt_entry_retired", retired_count, e.ret);
        end
      end
      halted_q = halted;
    end
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time bound exceeded");
  end

  initial begin
    logic [31:0] w;
    int          r;
    resetn = 1'b0; run = 1'b0; imem_ack = 1'b0; reg_write_in = 1'b0;
    imem_rdata = 32'd0;
    m_pc = RST_PC; m_ret = 32'd0; m_ir = 32'd0;
    do_reset();

    // First request one cycle after run; run drops mid-fetch, add still
    // retires, PC wraps to zero, then the sequencer parks in IDLE.
    run = 1'b1;
    step();
    check_bit("first_req_latency", imem_req, 1'b1);
    do_fetch(32'h0020_8033, 0, 1'b1);
    reg_write_in = 1'b1;
    step();
    step();
    check_bit("idle_after_run_drop", imem_req, 1'b0);
    check("pc_wrapped", pc, 32'h0000_0000);
    check("addr_wrapped", imem_addr, 32'h0000_0000);
    check("retired_one", retired_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom();
      step();
      check("idle_ack_ignored", instr, 32'h0020_8033);
      check_bit("idle_stays_idle", imem_req, 1'b0);
    end
    imem_ack = 1'b0;

    // Wait states, ack on the last allowed cycle, then EBREAK
    do_fetch(mk_alu(OP_I), 5, 1'b0);
    do_fetch(mk_alu(OP_R), TMO - 1, 1'b0);
    do_fetch(EBREAK, 0, 1'b0);
    hold_halt(1'b0);
    do_reset();

    // Fetch timeout
    do_fetch(mk_alu(OP_I), 1, 1'b0);
    do_fetch(32'd0, TMO, 1'b0);
    hold_halt(1'b1);
    do_reset();

    // Load opcode is unsupported
    do_fetch(mk_alu(OP_I), 0, 1'b0);
    do_fetch(mk_alu(OP_I), 0, 1'b0);
    do_fetch(32'h0000_0003, 0, 1'b0);
    hold_halt(1'b1);
    do_reset();

    // Reset while in EXEC
    do_fetch(mk_alu(OP_R), 0, 1'b0);
    do_fetch(mk_alu(OP_I), 2, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1; run = 1'b0;
    check_bit("exec_reset_valid", instr_valid, 1'b0);
    check_bit("exec_reset_req", imem_req, 1'b0);
    check("exec_reset_pc", pc, RST_PC);
    check("exec_reset_retired", retired_count, 32'd0);
    check("exec_reset_instr", instr, 32'd0);
    m_pc = RST_PC; m_ret = 32'd0; m_ir = 32'd0;

    // Randomised instruction stream
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      w = mk_alu(OP_R);
      else if (r < 75) w = mk_alu(OP_I);
      else if (r < 85) w = EBREAK;
      else             w = mk_illegal();
      if (r >= 93) begin
        do_fetch(32'd0, TMO, 1'($urandom_range(0, 1)));
        hold_halt(1'b1);
        do_reset();
      end else begin
        do_fetch(w, $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));
        if (!is_legal(w)) begin
          hold_halt(w != EBREAK);
          do_reset();
        end
      end
    end

    step();
    step();
    step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
